// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage (req/gnt/rvalid data bus, load alignment, regfile writeback).
// Optional MEM_MISALIGN_TRAP_EN: misaligned half/word accesses are trapped instead of truncated.
module mem_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] m_regfile_waddr_i,
    input  logic [DATA_WIDTH-1:0]     m_regfile_rd_i,
    input  logic                      m_regfile_wr_i,
    input  logic                      m_data_rd_i,
    input  logic                      m_data_wr_i,
    input  logic [DATA_WIDTH-1:0]     m_data_addr_i,
    input  logic [1:0]                m_data_write_transfer_i,
    input  logic                      m_is_load_store_i,
    input  logic [2:0]                m_LOAD_op_i,
    input  logic                      stall_general_i,
    output logic                      data_req_o,
    output logic                      data_we_o,
    output logic [DATA_WIDTH-1:0]     data_addr_o,
    output logic [DATA_WIDTH/8-1:0]   data_be_o,
    output logic [DATA_WIDTH-1:0]     data_wdata_o,
    input  logic                      data_gnt_i,
    input  logic                      data_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     data_rdata_i,
    output logic [REG_ADDR_WIDTH-1:0] w_regfile_waddr_o,
    output logic [DATA_WIDTH-1:0]     w_regfile_wd_o,
    output logic                      w_regfile_wr_o,
    output logic                      stall_mem_o,
    output logic                      misalign_o
);
    localparam int BE_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    state_e                    state_q, state_d;
    logic                      served_q, served_d;
    logic [DATA_WIDTH-1:0]     load_buf_q, load_buf_d;
    logic [REG_ADDR_WIDTH-1:0] w_waddr_q, w_waddr_d;
    logic [DATA_WIDTH-1:0]     w_wd_q, w_wd_d;
    logic                      w_wr_q, w_wr_d;

    logic                      access, misaligned, pending, resp;
    logic [1:0]                size, off;
    logic [BE_W-1:0]           be;
    logic [DATA_WIDTH-1:0]     wdata, src, load_data;
    logic [7:0]                byte_v;
    logic [15:0]               half_v;

    always_comb begin
        access = m_is_load_store_i & (m_data_rd_i | m_data_wr_i);
        size   = m_data_rd_i ? m_LOAD_op_i[1:0] : m_data_write_transfer_i;
        off    = m_data_addr_i[1:0];
`ifdef MEM_MISALIGN_TRAP_EN
        misaligned = access & (((size == 2'd1) & off[0]) | ((size == 2'd2) & (off != 2'b00)));
`else
        misaligned = 1'b0;
`endif
        // served blocks a second issue while the exe registers are frozen by another stall
        pending = access & ~served_q & ~misaligned;
        resp    = (state_q == WAIT) & data_rvalid_i;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pending) state_d = data_gnt_i ? WAIT : REQ;
            REQ:     if (data_gnt_i) state_d = WAIT;
            WAIT:    if (data_rvalid_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_req_o   = rst_n & ((state_q == REQ) | ((state_q == IDLE) & pending));
        be           = size == 2'd0 ? BE_W'(1) << off :
                       size == 2'd1 ? BE_W'(3) << {off[1], 1'b0} : '1;
        wdata        = size == 2'd0 ? {(DATA_WIDTH/8){m_regfile_rd_i[7:0]}} :
                       size == 2'd1 ? {(DATA_WIDTH/16){m_regfile_rd_i[15:0]}} : m_regfile_rd_i;
        data_we_o    = data_req_o & m_data_wr_i;
        data_addr_o  = data_req_o ? {m_data_addr_i[DATA_WIDTH-1:2], 2'b00} : '0;
        data_be_o    = data_req_o ? be : '0;
        data_wdata_o = data_req_o ? wdata : '0;
        stall_mem_o  = pending & ~resp;
    end

    always_comb begin
        src       = resp ? data_rdata_i : load_buf_q;
        byte_v    = src[{off, 3'b000} +: 8];
        half_v    = src[{off[1], 4'b0000} +: 16];
        load_data = m_LOAD_op_i == 3'b000 ? {{(DATA_WIDTH-8){byte_v[7]}}, byte_v} :
                    m_LOAD_op_i == 3'b001 ? {{(DATA_WIDTH-16){half_v[15]}}, half_v} :
                    m_LOAD_op_i == 3'b010 ? src :
                    m_LOAD_op_i == 3'b100 ? {{(DATA_WIDTH-8){1'b0}}, byte_v} :
                    m_LOAD_op_i == 3'b101 ? {{(DATA_WIDTH-16){1'b0}}, half_v} : '0;
    end

    always_comb begin
        served_d   = stall_general_i ? (served_q | resp) : 1'b0;
        load_buf_d = resp ? data_rdata_i : load_buf_q;
        w_waddr_d  = stall_general_i ? w_waddr_q : m_regfile_waddr_i;
        w_wd_d     = stall_general_i ? w_wd_q : (m_data_rd_i ? load_data : m_regfile_rd_i);
        w_wr_d     = ~stall_general_i & m_regfile_wr_i & ~misaligned;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            served_q   <= 1'b0;
            load_buf_q <= '0;
            w_waddr_q  <= '0;
            w_wd_q     <= '0;
            w_wr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            served_q   <= served_d;
            load_buf_q <= load_buf_d;
            w_waddr_q  <= w_waddr_d;
            w_wd_q     <= w_wd_d;
            w_wr_q     <= w_wr_d;
        end
    end

    assign w_regfile_waddr_o = w_waddr_q;
    assign w_regfile_wd_o    = w_wd_q;
    assign w_regfile_wr_o    = w_wr_q;

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;

    always_comb begin
        misalign_d = ~stall_general_i & misaligned;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign_o = misalign_q;
`else
    assign misalign_o = 1'b0;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven scoreboard bench for mem_stage with a req/gnt/rvalid bus responder.
// Honours MEM_MISALIGN_TRAP_EN when choosing expectations for the misaligned vector.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  m_regfile_waddr_i;
    logic [31:0] m_regfile_rd_i;
    logic        m_regfile_wr_i, m_data_rd_i, m_data_wr_i, m_is_load_store_i;
    logic [31:0] m_data_addr_i;
    logic [1:0]  m_data_write_transfer_i;
    logic [2:0]  m_LOAD_op_i;
    logic        stall_general, ext_stall;
    logic        data_req_o, data_we_o, data_gnt_i, data_rvalid_i;
    logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
    logic [3:0]  data_be_o;
    logic [4:0]  w_regfile_waddr_o;
    logic [31:0] w_regfile_wd_o;
    logic        w_regfile_wr_o, stall_mem_o, misalign_o;

    always #5 clk = ~clk;
    assign stall_general = stall_mem_o | ext_stall;

    mem_stage dut (
        .clk(clk), .rst_n(rst_n),
        .m_regfile_waddr_i(m_regfile_waddr_i), .m_regfile_rd_i(m_regfile_rd_i),
        .m_regfile_wr_i(m_regfile_wr_i), .m_data_rd_i(m_data_rd_i), .m_data_wr_i(m_data_wr_i),
        .m_data_addr_i(m_data_addr_i), .m_data_write_transfer_i(m_data_write_transfer_i),
        .m_is_load_store_i(m_is_load_store_i), .m_LOAD_op_i(m_LOAD_op_i),
        .stall_general_i(stall_general),
        .data_req_o(data_req_o), .data_we_o(data_we_o), .data_addr_o(data_addr_o),
        .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
        .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
        .w_regfile_waddr_o(w_regfile_waddr_o), .w_regfile_wd_o(w_regfile_wd_o),
        .w_regfile_wr_o(w_regfile_wr_o), .stall_mem_o(stall_mem_o), .misalign_o(misalign_o)
    );

    typedef struct {
        logic [4:0]  waddr;
        logic [31:0] rd;
        logic        wr, drd, dwr, ls;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [2:0]  op;
        logic [31:0] rdata;
        int          gnt_dly, ext;
        logic        chk_bus;
        logic [3:0]  be;
        logic [31:0] wdata, wd;
        logic        ewr, mis, mreq;
    } vec_t;

    typedef struct {
        logic [4:0]  waddr;
        logic [31:0] wd;
        logic        wr, mis;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[13];
    vec_t post;
    int   n_checks = 0, n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   req_cyc = 0, grants = 0, stalls = 0, waited = 0, adv_cyc = -1, exp_st;
        bit   granted = 1'b0, g, adv;
        exp_t e;
        @(negedge clk);
        m_regfile_waddr_i       = v.waddr;
        m_regfile_rd_i          = v.rd;
        m_regfile_wr_i          = v.wr;
        m_data_rd_i             = v.drd;
        m_data_wr_i             = v.dwr;
        m_is_load_store_i       = v.ls;
        m_data_addr_i           = v.addr;
        m_data_write_transfer_i = v.size;
        m_LOAD_op_i             = v.op;
        sb.push_back('{v.waddr, v.wd, v.ewr, v.mis});
        for (int c = 0; c < 40 && adv_cyc < 0; c++) begin
            ext_stall     = c < v.ext;
            data_rvalid_i = granted;
            data_rdata_i  = granted ? v.rdata : ~v.rdata;
            data_gnt_i    = 1'b0;
            #1;
            if (data_req_o) begin
                req_cyc++;
                data_gnt_i = waited >= v.gnt_dly;
                waited++;
                if (v.chk_bus) begin
                    chk($sformatf("v%0d be", idx), 32'(data_be_o), 32'(v.be));
                    chk($sformatf("v%0d addr", idx), data_addr_o, {v.addr[31:2], 2'b00});
                    chk($sformatf("v%0d we", idx), 32'(data_we_o), 32'(v.dwr));
                    if (v.dwr) chk($sformatf("v%0d wdata", idx), data_wdata_o, v.wdata);
                end
            end
            #1;
            g = data_gnt_i;
            if (g) grants++;
            if (stall_mem_o) stalls++;
            adv = !stall_general;
            @(posedge clk);
            #1;
            granted       = g;
            data_gnt_i    = 1'b0;
            data_rvalid_i = 1'b0;
            if (adv) adv_cyc = c;
            else chk($sformatf("v%0d bubble wr", idx), 32'(w_regfile_wr_o), 32'd0);
        end
        ext_stall = 1'b0;
        exp_st = v.mreq ? v.gnt_dly + 1 : 0;
        if (adv_cyc < 0) begin
            chk($sformatf("v%0d timeout", idx), 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d w_waddr", idx), 32'(w_regfile_waddr_o), 32'(e.waddr));
            chk($sformatf("v%0d w_wd", idx), w_regfile_wd_o, e.wd);
            chk($sformatf("v%0d w_wr", idx), 32'(w_regfile_wr_o), 32'(e.wr));
            chk($sformatf("v%0d misalign", idx), 32'(misalign_o), 32'(e.mis));
            chk($sformatf("v%0d latency", idx), 32'(adv_cyc), 32'(v.ext > exp_st ? v.ext : exp_st));
        end
        chk($sformatf("v%0d grants", idx), 32'(grants), 32'(v.mreq));
        chk($sformatf("v%0d req cycles", idx), 32'(req_cyc), 32'(exp_st));
        chk($sformatf("v%0d stall cycles", idx), 32'(stalls), 32'(exp_st));
    endtask

    initial begin
        //           waddr  rd            wr    drd   dwr   ls    addr        size  op      rdata         g  x  chk   be     wdata          wd            ewr   mis   mreq
        vecs[0]  = '{5'd5,  32'h1234,     1'b1, 1'b0, 1'b0, 1'b0, 32'h0,      2'd0, 3'b000, 32'h0,        0, 0, 1'b0, 4'h0,  32'h0,         32'h1234,     1'b1, 1'b0, 1'b0};
        vecs[1]  = '{5'd6,  32'hDEAD,     1'b1, 1'b1, 1'b0, 1'b1, 32'h103,    2'd0, 3'b000, 32'h80FF0000, 0, 0, 1'b1, 4'h8,  32'h0,         32'hFFFFFF80, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{5'd7,  32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'h202,    2'd0, 3'b101, 32'hBEEF0000, 3, 0, 1'b1, 4'hC,  32'h0,         32'h0000BEEF, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{5'd0,  32'hA5,       1'b0, 1'b0, 1'b1, 1'b1, 32'h301,    2'd0, 3'b000, 32'h0,        0, 0, 1'b1, 4'h2,  32'hA5A5A5A5,  32'hA5,       1'b0, 1'b0, 1'b1};
        vecs[4]  = '{5'd8,  32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'h400,    2'd0, 3'b010, 32'h12345678, 0, 4, 1'b1, 4'hF,  32'h0,         32'h12345678, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{5'd9,  32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'h106,    2'd0, 3'b001, 32'h80017FFF, 1, 0, 1'b1, 4'hC,  32'h0,         32'hFFFF8001, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{5'd10, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'h101,    2'd0, 3'b100, 32'h00009A00, 0, 0, 1'b1, 4'h2,  32'h0,         32'h0000009A, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{5'd11, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'h100,    2'd0, 3'b000, 32'h00000072, 2, 0, 1'b1, 4'h1,  32'h0,         32'h00000072, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{5'd12, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'h100,    2'd0, 3'b011, 32'hFFFFFFFF, 0, 0, 1'b0, 4'h0,  32'h0,         32'h0,        1'b1, 1'b0, 1'b1};
        vecs[9]  = '{5'd13, 32'hBEEF,     1'b1, 1'b0, 1'b1, 1'b1, 32'h302,    2'd1, 3'b000, 32'h0,        1, 0, 1'b1, 4'hC,  32'hBEEFBEEF,  32'hBEEF,     1'b1, 1'b0, 1'b1};
        vecs[10] = '{5'd14, 32'h11223344, 1'b0, 1'b0, 1'b1, 1'b1, 32'h304,    2'd2, 3'b000, 32'h0,        0, 0, 1'b1, 4'hF,  32'h11223344,  32'h11223344, 1'b0, 1'b0, 1'b1};
`ifdef MEM_MISALIGN_TRAP_EN
        vecs[11] = '{5'd15, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'h402,    2'd0, 3'b010, 32'hCAFEF00D, 0, 0, 1'b0, 4'h0,  32'h0,         32'h0,        1'b0, 1'b1, 1'b0};
`else
        vecs[11] = '{5'd15, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'h402,    2'd0, 3'b010, 32'hCAFEF00D, 0, 0, 1'b1, 4'hF,  32'h0,         32'hCAFEF00D, 1'b1, 1'b0, 1'b1};
`endif
        vecs[12] = '{5'd16, 32'h55,       1'b1, 1'b0, 1'b0, 1'b0, 32'h0,      2'd0, 3'b000, 32'h0,        0, 2, 1'b0, 4'h0,  32'h0,         32'h55,       1'b1, 1'b0, 1'b0};
        post     = '{5'd17, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'h600,    2'd0, 3'b010, 32'h0BADCAFE, 1, 0, 1'b1, 4'hF,  32'h0,         32'h0BADCAFE, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0; ext_stall = 1'b0;
        m_regfile_waddr_i = '0; m_regfile_rd_i = '0; m_regfile_wr_i = 1'b0;
        m_data_rd_i = 1'b0; m_data_wr_i = 1'b0; m_is_load_store_i = 1'b0;
        m_data_addr_i = '0; m_data_write_transfer_i = '0; m_LOAD_op_i = '0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset w_wr", 32'(w_regfile_wr_o), 32'd0);
        chk("reset w_wd", w_regfile_wd_o, 32'd0);
        chk("reset w_waddr", 32'(w_regfile_waddr_o), 32'd0);
        chk("reset misalign", 32'(misalign_o), 32'd0);
        chk("reset req", 32'(data_req_o), 32'd0);
        chk("reset stall", 32'(stall_mem_o), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

        // reset while a load sits in WAIT; the late rvalid must be ignored
        @(negedge clk);
        m_regfile_waddr_i = 5'd20; m_regfile_wr_i = 1'b1; m_data_rd_i = 1'b1;
        m_is_load_store_i = 1'b1; m_data_addr_i = 32'h500; m_LOAD_op_i = 3'b010;
        #1;
        chk("rst seq req", 32'(data_req_o), 32'd1);
        data_gnt_i = 1'b1;
        @(posedge clk);
        #1;
        data_gnt_i = 1'b0;
        chk("rst seq wait req", 32'(data_req_o), 32'd0);
        chk("rst seq wait stall", 32'(stall_mem_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b0; m_is_load_store_i = 1'b0; m_data_rd_i = 1'b0; m_regfile_wr_i = 1'b0;
        @(posedge clk);
        #1;
        chk("rst seq req after reset", 32'(data_req_o), 32'd0);
        chk("rst seq w_wr after reset", 32'(w_regfile_wr_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; data_rvalid_i = 1'b1; data_rdata_i = 32'hFEEDFACE;
        #1;
        chk("late rvalid stall", 32'(stall_mem_o), 32'd0);
        chk("late rvalid req", 32'(data_req_o), 32'd0);
        @(posedge clk);
        #1;
        data_rvalid_i = 1'b0;
        chk("late rvalid w_wr", 32'(w_regfile_wr_o), 32'd0);
        run_vec(99, post);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
